// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: product/carry/multiplicand registers and iteration counter.
// Optional MULT_OVF_EN: drive ovf when the finished product exceeds WIDTH bits.
module mult_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrt,
  input  logic               add,
  input  logic               shr,
  input  logic               incr,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               less32,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CMAX = CW'(WIDTH);

  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               c_q, c_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     hi;
  logic [2*WIDTH:0]   cp;

  always_comb begin
    sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
    hi    = {c_q, p_q[2*WIDTH-1:WIDTH]};
    if (add && p_q[0]) hi = sum;
    cp    = {hi, p_q[WIDTH-1:0]};
    p_d   = p_q;
    c_d   = c_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    if (wrt) begin
      p_d   = {{WIDTH{1'b0}}, b};
      m_d   = a;
      c_d   = 1'b0;
      cnt_d = '0;
    end else begin
      // Sum lands first; a same-cycle shift consumes the carry.
      if (shr) begin
        p_d = cp[2*WIDTH:1];
        c_d = 1'b0;
      end else begin
        p_d = cp[2*WIDTH-1:0];
        c_d = cp[2*WIDTH];
      end
      if (incr && (cnt_q < CMAX)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      m_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      p_q   <= p_d;
      m_q   <= m_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
    end
  end

  assign product = p_q;
  assign less32  = (cnt_q < CMAX);
  assign done    = (cnt_q == CMAX);

`ifdef MULT_OVF_EN
  assign ovf = done & (|p_q[2*WIDTH-1:WIDTH]);
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/mult_datapath.md
MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; the product is 2*WIDTH bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 wrt  input  1  load strobe: capture operands and restart the multiply.
REQ-005 add  input  1  conditional-add strobe from the controller.
REQ-006 shr  input  1  shift-right strobe from the controller.
REQ-007 incr  input  1  iteration-counter increment strobe from the controller.
REQ-008 a  input  WIDTH  multiplicand, unsigned.
REQ-009 b  input  WIDTH  multiplier, unsigned.
REQ-010 less32  output  1  high while iteration count < WIDTH; feeds the controller.
REQ-011 done  output  1  high while iteration count == WIDTH.
REQ-012 product  output  2*WIDTH  product register P, driven directly from the flop.
REQ-013 ovf  output  1  overflow flag; see Configuration.

Function
REQ-014 Internal state: P[2*WIDTH-1:0], M[WIDTH-1:0], carry bit C, counter CNT[$clog2(WIDTH):0].
REQ-015 wrt=1: P<={WIDTH'b0, b}, M<=a, C<=0, CNT<=0, all in the same edge.
REQ-016 wrt has priority: add/shr/incr are ignored in any cycle where wrt=1.
REQ-017 add=1 and P[0]=1: {C, P[2W-1:W]} <= P[2W-1:W] + M, a (WIDTH+1)-bit unsigned sum.
REQ-018 add=1 and P[0]=0: P and C are unchanged.
REQ-019 shr=1 alone: P<={C, P[2W-1:1]}, C<=0.
REQ-020 add=1 and shr=1 in the same cycle: the conditional sum is formed first and the combined {C,P} is shifted right by one; one edge, C<=0.
REQ-021 incr=1: CNT<=CNT+1 when CNT<WIDTH; CNT saturates at WIDTH (no wrap).
REQ-022 less32=(CNT<WIDTH), done=(CNT==WIDTH); both are combinational from CNT, with zero-cycle latency after the CNT edge.
REQ-023 After wrt, WIDTH rounds of add+shr+incr (any cycle split) leave P = a*b with done=1.
REQ-024 A strobe arriving after done (CNT==WIDTH) still updates P/C per REQ-017..020; only CNT holds.
REQ-025 No strobes asserted: all registers hold.

Reset
REQ-026 rst=1 at the edge: P=0, M=0, C=0, CNT=0, so product=0, less32=1, done=0, ovf=0.
REQ-027 rst has priority over wrt and all strobes, including during an in-progress multiply; no partial state survives.

Configuration
REQ-028 Macro MULT_OVF_EN defined: ovf = done & (|P[2W-1:W]), i.e. the product does not fit in WIDTH bits.
REQ-029 MULT_OVF_EN undefined: the ovf port still exists, is tied to 0, and no compare logic is synthesized.

Verification
REQ-030 rst, wrt a=3 b=5, then 32 cycles of add=shr=incr=1 -> product=0x0000_0000_0000_000F, done=1, less32=0, ovf=0.
REQ-031 wrt a=b=0xFFFFFFFF, 32 rounds of add,shr,incr on separate cycles -> product=0xFFFFFFFE_00000001; with MULT_OVF_EN ovf=1, without it ovf=0.
REQ-032 wrt a=7 b=9, 10 rounds, then wrt a=2 b=6 with add=1 in the same cycle -> P=0x...0006, CNT=0, M=2; after 32 rounds product=12.
REQ-033 Mid-multiply rst=1 with shr=incr=1 -> next cycle product=0, less32=1, done=0.
REQ-034 After done, 3 extra incr pulses -> done stays 1 and less32 stays 0 (no wrap); with add=1 and P[0]=1, C:P updates per REQ-017.
